// File: rtl/ntt_result_drain.sv
// ntt_result_drain: drains packed {data_out2, data_out1} result FIFO words into a 16-bit coefficient stream.
// Optional running checksum of accepted beats is built when NTT_DRAIN_CHECKSUM_EN is defined.
module ntt_result_drain #(
  parameter int DATA_W  = 16,
  parameter int WORD_W  = 32,
  parameter int N_WORDS = 128,
  parameter int CNT_W   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              fifo_rd_empty,
  input  logic [WORD_W-1:0] fifo_rd_data,
  output logic              fifo_rd_req,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_WAIT    = 3'd2,
    S_EMIT_LO = 3'd3,
    S_EMIT_HI = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_WORDS - 1);

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                rd_req_q, rd_req_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                accept_s;

  assign accept_s = out_valid_q & out_ready;

  // Next-state and registered-output decode; outputs are derived from the next state so they
  // line up with the state register. The read request is raised from the empty flag seen on
  // the entry edge: only this block pops the FIFO, so a non-empty FIFO stays non-empty.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    rd_req_d = 1'b0;
    count_d  = count_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d  = S_FETCH;
            count_d  = {CNT_W{1'b0}};
            rd_req_d = ~fifo_rd_empty;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          if (rd_req_q) begin
            state_d = S_WAIT;
          end else if (!fifo_rd_empty) begin
            rd_req_d = 1'b1;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WAIT: begin
          word_d  = fifo_rd_data;
          state_d = S_EMIT_LO;
        end
        S_EMIT_LO: begin
          if (accept_s) begin
            state_d = S_EMIT_HI;
          end else begin
            state_d = S_EMIT_LO;
          end
        end
        S_EMIT_HI: begin
          if (accept_s) begin
            count_d = count_q + CNT_W'(1);
            if (count_q == LAST_CNT) begin
              state_d = S_DONE;
            end else begin
              state_d  = S_FETCH;
              rd_req_d = ~fifo_rd_empty;
            end
          end else begin
            state_d = S_EMIT_HI;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    out_valid_d = (state_d == S_EMIT_LO) || (state_d == S_EMIT_HI);
    if (state_d == S_EMIT_LO) begin
      out_data_d = word_d[DATA_W-1:0];
    end else if (state_d == S_EMIT_HI) begin
      out_data_d = word_q[WORD_W-1:DATA_W];
    end else begin
      out_data_d = out_data_q;
    end
    out_last_d = (state_d == S_EMIT_HI) && (count_d == LAST_CNT);
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, captured word and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      word_q      <= {WORD_W{1'b0}};
      rd_req_q    <= 1'b0;
      out_data_q  <= {DATA_W{1'b0}};
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      rd_req_q    <= rd_req_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      count_q     <= count_d;
    end
  end

`ifdef NTT_DRAIN_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  // Running sum of accepted beats; held across abort and after completion.
  always_comb begin
    sum_d = sum_q;
    if (abort) begin
      sum_d = sum_q;
    end else if ((state_q == S_IDLE) && start) begin
      sum_d = {DATA_W{1'b0}};
    end else if (accept_s) begin
      sum_d = sum_q + out_data_q;
    end else begin
      sum_d = sum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= {DATA_W{1'b0}};
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = {DATA_W{1'b0}};
`endif

  assign fifo_rd_req = rd_req_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign word_count  = count_q;

endmodule

// File: tb/tb_ntt_result_drain.sv
// Bench for ntt_result_drain: queue-based FIFO and beat scoreboard, directed steps with random data/ready.
module tb_ntt_result_drain;
  localparam int NW = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, out_ready;
  logic        fifo_rd_empty, fifo_rd_req;
  logic [31:0] fifo_rd_data = 32'h0;
  logic [15:0] out_data, checksum;
  logic        out_valid, out_last, busy, done;
  logic [8:0]  word_count;

  int total = 0;
  int bad   = 0;

  logic [31:0] fifo_q[$];
  logic [15:0] exp_q[$];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int beat_idx = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  logic [15:0] cs_model = 16'h0;

  always #5 clk = ~clk;

  assign fifo_rd_empty = (wr_cnt == rd_cnt);

  ntt_result_drain #(.N_WORDS(NW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .fifo_rd_empty(fifo_rd_empty), .fifo_rd_data(fifo_rd_data), .fifo_rd_req(fifo_rd_req),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .word_count(word_count), .checksum(checksum)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_cs();
`ifdef NTT_DRAIN_CHECKSUM_EN
    return cs_model;
`else
    return 16'h0;
`endif
  endfunction

  // Result FIFO model: one-cycle read latency
  always @(posedge clk) begin
    if (fifo_rd_req) begin
      chk("rd_on_empty", 64'(fifo_q.size() != 0), 64'd1);
      if (fifo_q.size() != 0) begin
        fifo_rd_data <= fifo_q.pop_front();
        rd_cnt       <= rd_cnt + 1;
      end
    end
  end

  // Scoreboard: each accepted beat must be the next expected coefficient
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_cnt++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", 64'(exp_q.size()), 64'd1);
        end else begin
          chk("beat_data", 64'(out_data), 64'(exp_q.pop_front()));
          chk("beat_last", 64'(out_last), 64'(beat_idx == 2 * NW - 1));
        end
        beat_idx++;
        acc_cnt++;
        cs_model = cs_model + out_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w[15:0]);
    exp_q.push_back(w[31:16]);
    wr_cnt++;
  endtask

  task automatic flush();
    fifo_q.delete();
    exp_q.delete();
    wr_cnt = rd_cnt;
  endtask

  task automatic pulse_start();
    beat_idx = 0;
    acc_cnt  = 0;
    cs_model = 16'h0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 60 && !out_valid; i++) tick();
    chk("wait_valid", 64'(out_valid), 64'd1);
  endtask

  task automatic run_done(input bit rnd);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    chk("done_seen", 64'(done_cnt != d0), 64'd1);
    out_ready = 1'b0;
    tick();
    tick();
    chk("done_once", 64'(done_cnt), 64'(d0 + 1));
    chk("idle_after_done", 64'(busy), 64'd0);
    chk("word_count_final", 64'(word_count), 64'(NW));
    chk("checksum_final", 64'(checksum), 64'(exp_cs()));
    chk("all_beats_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {fifo_rd_req, out_data, out_valid, out_last, busy, done, word_count, checksum}, 64'd0);
  endtask

  initial begin
    logic [31:0] w0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    chk_all_zero("reset_state");
    rst_n = 1'b1;
    tick();

    // reset in the middle of EMIT_LO
    push($urandom());
    pulse_start();
    wait_valid();
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_mid_emit");
    tick();
    rst_n = 1'b1;
    flush();
    push($urandom());
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("idle_no_req", 64'(fifo_rd_req), 64'd0);
      chk("idle_not_busy", 64'(busy), 64'd0);
    end
    flush();
    tick();

    // full drain with minimum-latency checks
    push(32'h0002_0001); push(32'h0004_0003); push(32'h0006_0005); push(32'h0008_0007);
    out_ready = 1'b1;
    pulse_start();
    chk("lat_req_c1", 64'(fifo_rd_req), 64'd1);
    tick();
    chk("lat_req_c2", 64'(fifo_rd_req), 64'd0);
    chk("lat_valid_c2", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid_c3", 64'(out_valid), 64'd1);
    chk("lat_data_c3", 64'(out_data), 64'h0001);
    run_done(1'b0);
    chk("full_beats", 64'(acc_cnt), 64'd8);
`ifdef NTT_DRAIN_CHECKSUM_EN
    chk("full_checksum", 64'(checksum), 64'h0024);
`else
    chk("full_checksum", 64'(checksum), 64'h0000);
`endif

    // empty stall
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      chk("stall_no_req", 64'(fifo_rd_req), 64'd0);
      chk("stall_busy", 64'(busy), 64'd1);
      tick();
    end
    push(32'hBEEF_CAFE);
    for (int i = 0; i < NW - 1; i++) push($urandom());
    run_done(1'b0);

    // backpressure during EMIT_HI
    push(32'h1234_5678);
    for (int i = 0; i < NW - 1; i++) push($urandom());
    out_ready = 1'b0;
    pulse_start();
    wait_valid();
    chk("bp_lo_data", 64'(out_data), 64'h5678);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_data", 64'(out_data), 64'h1234);
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_count", 64'(word_count), 64'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_count_inc", 64'(word_count), 64'd1);
    run_done(1'b1);

    // abort after three accepted beats
    for (int i = 0; i < NW; i++) push($urandom());
    out_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 60 && acc_cnt < 3; i++) tick();
    chk("abort_reach", 64'(acc_cnt), 64'd3);
    out_ready = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_req", 64'(fifo_rd_req), 64'd0);
    chk("abort_last", 64'(out_last), 64'd0);
    chk("abort_count", 64'(word_count), 64'd1);
    chk("abort_checksum", 64'(checksum), 64'(exp_cs()));
    flush();
    tick();
    pulse_start();
    chk("restart_count", 64'(word_count), 64'd0);
    chk("restart_busy", 64'(busy), 64'd1);
    for (int i = 0; i < NW; i++) push($urandom());
    run_done(1'b1);

    // start while busy is ignored
    w0 = $urandom();
    push(w0);
    for (int i = 0; i < NW - 1; i++) push($urandom());
    out_ready = 1'b0;
    pulse_start();
    wait_valid();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_start_data", 64'(out_data), 64'(w0[15:0]));
    chk("busy_start_count", 64'(word_count), 64'd0);
    chk("busy_start_valid", 64'(out_valid), 64'd1);
    run_done(1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
